// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the DRAM port and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req_ip;
  logic [AW-1:0] if_addr_ip;
  logic          if_gnt_op;
  logic          if_rvalid_op;
  logic [31:0]   if_rdata_op;

  logic          lsu_req_ip;
  logic          lsu_we_ip;
  logic [AW-1:0] lsu_addr_ip;
  logic [31:0]   lsu_wdata_ip;
  logic          lsu_gnt_op;
  logic          lsu_rvalid_op;
  logic [31:0]   lsu_rdata_op;

  logic          mem_req_op;
  logic          mem_we_op;
  logic [AW-1:0] mem_addr_op;
  logic [31:0]   mem_wdata_op;
  logic          mem_rvalid_ip;
  logic [31:0]   mem_rdata_ip;

  modport slave (
    input  if_req_ip, if_addr_ip,
    output if_gnt_op, if_rvalid_op, if_rdata_op,
    input  lsu_req_ip, lsu_we_ip, lsu_addr_ip, lsu_wdata_ip,
    output lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
    output mem_req_op, mem_we_op, mem_addr_op, mem_wdata_op,
    input  mem_rvalid_ip, mem_rdata_ip
  );

  modport master (
    output if_req_ip, if_addr_ip,
    input  if_gnt_op, if_rvalid_op, if_rdata_op,
    output lsu_req_ip, lsu_we_ip, lsu_addr_ip, lsu_wdata_ip,
    input  lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
    input  mem_req_op, mem_we_op, mem_addr_op, mem_wdata_op,
    output mem_rvalid_ip, mem_rdata_ip
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding DRAM port arbiter for fetch and LSU with response timeout.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous requests instead of fixed LSU priority.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int AW          = 32
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              if_stall_op,
  output logic              err_op
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_LSU = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pend_we_q, pend_we_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_lsu_q, last_lsu_d;
`endif

  logic          arb_en, pick_lsu, pick_if;
  logic          if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, mem_req, mem_we;
  logic [31:0]   if_rdata, lsu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_lsu = bus.lsu_req_ip && (!bus.if_req_ip || !last_lsu_q);
`else
    pick_lsu = bus.lsu_req_ip;
`endif
    pick_if = bus.if_req_ip && !pick_lsu;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pend_we_d  = pend_we_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_lsu_d = last_lsu_q;
`endif
    arb_en     = 1'b0;
    if_gnt     = 1'b0;
    lsu_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;
    if_rdata   = '0;
    lsu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: arb_en = 1'b1;
        BUSY_IF, BUSY_LSU: begin
          if (bus.mem_rvalid_ip) begin
            if (state_q == BUSY_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = bus.mem_rdata_ip;
            end else begin
              lsu_rvalid = 1'b1;
              lsu_rdata  = pend_we_q ? 32'd0 : bus.mem_rdata_ip;
            end
            state_d = IDLE;
            arb_en  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: the requester gets a zero-data response so it never hangs.
            if (state_q == BUSY_IF) if_rvalid = 1'b1;
            else                    lsu_rvalid = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (arb_en && pick_lsu) begin
        lsu_gnt   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = bus.lsu_we_ip;
        mem_addr  = bus.lsu_addr_ip;
        mem_wdata = bus.lsu_wdata_ip;
        pend_we_d = bus.lsu_we_ip;
        cnt_d     = '0;
        state_d   = BUSY_LSU;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu_d = 1'b1;
`endif
      end else if (arb_en && pick_if) begin
        if_gnt    = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = bus.if_addr_ip;
        pend_we_d = 1'b0;
        cnt_d     = '0;
        state_d   = BUSY_IF;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      pend_we_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      pend_we_q  <= pend_we_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu_q <= last_lsu_d;
`endif
    end
  end

  assign bus.if_gnt_op     = if_gnt;
  assign bus.if_rvalid_op  = if_rvalid;
  assign bus.if_rdata_op   = if_rdata;
  assign bus.lsu_gnt_op    = lsu_gnt;
  assign bus.lsu_rvalid_op = lsu_rvalid;
  assign bus.lsu_rdata_op  = lsu_rdata;
  assign bus.mem_req_op    = mem_req;
  assign bus.mem_we_op     = mem_we;
  assign bus.mem_addr_op   = mem_addr;
  assign bus.mem_wdata_op  = mem_wdata;
  assign if_stall_op       = bus.if_req_ip && !if_gnt;
  assign err_op            = err_q;
endmodule
